// File: rtl/fta_bus_pkg.sv
// Request/response types of the fta 128-bit master port.
package fta_bus_pkg;

  typedef enum logic [4:0] {
    CMD_NONE  = 5'd0,
    CMD_LOAD  = 5'd1,
    CMD_STORE = 5'd2,
    CMD_LOADZ = 5'd3,
    CMD_IO    = 5'd4
  } fta_cmd_t;

  typedef struct packed {
    logic [5:0] core;
    logic [2:0] channel;
    logic [3:0] tranid;
  } fta_tranid_t;

  typedef struct packed {
    fta_tranid_t  tid;
    fta_cmd_t     cmd;
    logic         cyc;
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  adr;
    logic [127:0] data1;
  } fta_cmd_request128_t;

  typedef struct packed {
    fta_tranid_t  tid;
    logic         ack;
    logic         rty;
    logic         err;
    logic [31:0]  adr;
    logic [127:0] dat;
  } fta_cmd_response128_t;

endpackage

// File: rtl/rf80386_pkg.sv
// Shared arbiter types: owner-table entry and requester encodings.
package rf80386_pkg;

  localparam int NUM_TID = 16;

  localparam logic REQ_INSN = 1'b0;
  localparam logic REQ_DATA = 1'b1;

  typedef struct packed {
    logic valid;
    logic req;
  } owner_entry_t;

endpackage

// File: rtl/rf80386_tid_table.sv
// Owner table indexed by tranid plus the outstanding-transaction counter.
module rf80386_tid_table
  import rf80386_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       alloc_i,
  input  logic [3:0] alloc_tid_i,
  input  logic       alloc_req_i,
  output logic       alloc_busy_o,
  input  logic       lookup_i,
  input  logic [3:0] lookup_tid_i,
  output logic       hit_o,
  output logic       hit_req_o,
  output logic [3:0] outstanding_o
);

  owner_entry_t [NUM_TID-1:0] owner_q, owner_d;
  logic [3:0] outstanding_q, outstanding_d;

  assign alloc_busy_o  = owner_q[alloc_tid_i].valid;
  assign hit_o         = lookup_i && owner_q[lookup_tid_i].valid;
  assign hit_req_o     = owner_q[lookup_tid_i].req;
  assign outstanding_o = outstanding_q;

  // Alloc needs an invalid entry and free needs a valid one, so they never collide.
  always_comb begin
    owner_d       = owner_q;
    outstanding_d = outstanding_q;
    if (alloc_i) begin
      owner_d[alloc_tid_i].valid = 1'b1;
      owner_d[alloc_tid_i].req   = alloc_req_i;
    end
    if (hit_o) begin
      owner_d[lookup_tid_i].valid = 1'b0;
    end
    case ({alloc_i, hit_o})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_q       <= '0;
      outstanding_q <= 4'd0;
    end else begin
      owner_q       <= owner_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule

// File: rtl/rf80386_bus_arb.sv
// Two-requester round-robin arbiter in front of the fta master port,
// with tranid stamping and response routing.
module rf80386_bus_arb
  import fta_bus_pkg::*;
  import rf80386_pkg::*;
#(
  parameter logic [5:0] CORENO  = 6'd1,
  parameter logic [2:0] CID     = 3'd1,
  parameter int         MAX_OUT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  fta_cmd_request128_t  ireq_i,
  output logic                 irdy_o,
  output fta_cmd_response128_t iresp_o,
  input  fta_cmd_request128_t  dreq_i,
  output logic                 drdy_o,
  output fta_cmd_response128_t dresp_o,
  output fta_cmd_request128_t  ftam_req,
  input  fta_cmd_response128_t ftam_resp,
  input  logic                 bus_busy_i,
  output logic                 orphan_o,
  output logic [3:0]           outstanding_o
);

  localparam logic [3:0] MAX_OUT_L = 4'(MAX_OUT);

  fta_cmd_request128_t  islot_q, islot_d, dslot_q, dslot_d;
  fta_cmd_request128_t  ftam_req_q, ftam_req_d;
  fta_cmd_response128_t iresp_q, iresp_d, dresp_q, dresp_d;
  logic       ifull_q, ifull_d, dfull_q, dfull_d;
  logic       rr_q, rr_d;
  logic [3:0] tranid_q, tranid_d;
  logic       orphan_q, orphan_d;

  logic can_issue, ins_elig, data_elig, issue, pick_data;
  logic alloc_busy, resp_valid, resp_hit, hit_req;

  // The counter never skips a busy tranid, so a still-owned entry stalls issue.
  assign can_issue  = !bus_busy_i && (outstanding_o < MAX_OUT_L) && !alloc_busy;
  assign ins_elig   = ifull_q && can_issue;
  assign data_elig  = dfull_q && can_issue;
  assign issue      = ins_elig || data_elig;
  assign pick_data  = data_elig && (!ins_elig || (rr_q == REQ_DATA));
  assign resp_valid = ftam_resp.ack || ftam_resp.rty;

  rf80386_tid_table u_tid_table (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .alloc_i      (issue),
    .alloc_tid_i  (tranid_q),
    .alloc_req_i  (pick_data),
    .alloc_busy_o (alloc_busy),
    .lookup_i     (resp_valid),
    .lookup_tid_i (ftam_resp.tid.tranid),
    .hit_o        (resp_hit),
    .hit_req_o    (hit_req),
    .outstanding_o(outstanding_o)
  );

  always_comb begin
    islot_d    = islot_q;
    dslot_d    = dslot_q;
    ifull_d    = ifull_q;
    dfull_d    = dfull_q;
    rr_d       = rr_q;
    tranid_d   = tranid_q;
    ftam_req_d = '0;
    iresp_d    = '0;
    dresp_d    = '0;
    orphan_d   = resp_valid && !resp_hit;

    if (issue) begin
      ftam_req_d            = pick_data ? dslot_q : islot_q;
      ftam_req_d.tid.core    = CORENO;
      ftam_req_d.tid.channel = CID;
      ftam_req_d.tid.tranid  = tranid_q;
      tranid_d = (tranid_q == 4'd15) ? 4'd1 : tranid_q + 4'd1;
      if (pick_data) dfull_d = 1'b0;
      else           ifull_d = 1'b0;
      if (ins_elig && data_elig) rr_d = pick_data ? REQ_INSN : REQ_DATA;
    end

    if (ireq_i.cyc && !ifull_q) begin
      islot_d = ireq_i;
      ifull_d = 1'b1;
    end
    if (dreq_i.cyc && !dfull_q) begin
      dslot_d = dreq_i;
      dfull_d = 1'b1;
    end

    if (resp_hit) begin
      if (hit_req == REQ_DATA) dresp_d = ftam_resp;
      else                     iresp_d = ftam_resp;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      islot_q    <= '0;
      dslot_q    <= '0;
      ifull_q    <= 1'b0;
      dfull_q    <= 1'b0;
      rr_q       <= REQ_INSN;
      tranid_q   <= 4'd1;
      ftam_req_q <= '0;
      iresp_q    <= '0;
      dresp_q    <= '0;
      orphan_q   <= 1'b0;
    end else begin
      islot_q    <= islot_d;
      dslot_q    <= dslot_d;
      ifull_q    <= ifull_d;
      dfull_q    <= dfull_d;
      rr_q       <= rr_d;
      tranid_q   <= tranid_d;
      ftam_req_q <= ftam_req_d;
      iresp_q    <= iresp_d;
      dresp_q    <= dresp_d;
      orphan_q   <= orphan_d;
    end
  end

  assign irdy_o   = !ifull_q;
  assign drdy_o   = !dfull_q;
  assign ftam_req = ftam_req_q;
  assign iresp_o  = iresp_q;
  assign dresp_o  = dresp_q;
  assign orphan_o = orphan_q;

endmodule

// File: tb/tb_rf80386_bus_arb.sv
// Table-driven bench for rf80386_bus_arb plus directed multi-cycle sequences.
module tb_rf80386_bus_arb;
  import fta_bus_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  fta_cmd_request128_t  ireq_i, dreq_i, ftam_req;
  fta_cmd_response128_t iresp_o, dresp_o, ftam_resp;
  logic                 irdy_o, drdy_o, bus_busy_i, orphan_o;
  logic [3:0]           outstanding_o;

  int checks = 0;
  int errors = 0;

  logic [3:0]  seen_tid[$];
  logic [31:0] seen_adr[$];

  rf80386_bus_arb #(.CORENO(6'd1), .CID(3'd1), .MAX_OUT(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ireq_i       (ireq_i),
    .irdy_o       (irdy_o),
    .iresp_o      (iresp_o),
    .dreq_i       (dreq_i),
    .drdy_o       (drdy_o),
    .dresp_o      (dresp_o),
    .ftam_req     (ftam_req),
    .ftam_resp    (ftam_resp),
    .bus_busy_i   (bus_busy_i),
    .orphan_o     (orphan_o),
    .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  // Log every bus issue mid-cycle so sequences can check ordering afterwards.
  always @(negedge clk_i) begin
    if (ftam_req.cyc) begin
      seen_tid.push_back(ftam_req.tid.tranid);
      seen_adr.push_back(ftam_req.adr);
    end
  end

  typedef struct {
    logic        icyc;
    logic [31:0] iadr;
    logic        dcyc;
    logic [31:0] dadr;
    logic        busy;
    logic        ack;
    logic        rty;
    logic [3:0]  rtid;
    logic        ecyc;
    logic [3:0]  etid;
    logic [31:0] eadr;
    logic        eirdy;
    logic        edrdy;
    logic        eiack;
    logic        eirty;
    logic        edack;
    logic        edrty;
    logic        eorph;
    logic [3:0]  eout;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic icyc, logic [31:0] iadr, logic dcyc, logic [31:0] dadr,
                              logic busy, logic ack, logic rty, logic [3:0] rtid,
                              logic ecyc, logic [3:0] etid, logic [31:0] eadr,
                              logic eirdy, logic edrdy, logic eiack, logic eirty,
                              logic edack, logic edrty, logic eorph, logic [3:0] eout);
    vec_t v;
    v.icyc = icyc; v.iadr = iadr; v.dcyc = dcyc; v.dadr = dadr; v.busy = busy;
    v.ack = ack; v.rty = rty; v.rtid = rtid; v.ecyc = ecyc; v.etid = etid; v.eadr = eadr;
    v.eirdy = eirdy; v.edrdy = edrdy; v.eiack = eiack; v.eirty = eirty;
    v.edack = edack; v.edrty = edrty; v.eorph = eorph; v.eout = eout;
    return v;
  endfunction

  function automatic fta_cmd_request128_t mkReq(logic cyc, logic [31:0] adr);
    fta_cmd_request128_t r;
    r = '0;
    if (cyc) begin
      r.cmd = CMD_LOAD;
      r.cyc = 1'b1;
      r.sel = 16'hFFFF;
      r.adr = adr;
    end
    return r;
  endfunction

  function automatic fta_cmd_response128_t mkResp(logic ack, logic rty, logic [3:0] tid);
    fta_cmd_response128_t r;
    r = '0;
    r.ack = ack;
    r.rty = rty;
    if (ack || rty) begin
      r.tid.core    = 6'd1;
      r.tid.channel = 3'd1;
      r.tid.tranid  = tid;
      r.dat         = {96'd0, 28'hBEEF000, tid};
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic icyc, input logic [31:0] iadr, input logic dcyc,
                       input logic [31:0] dadr, input logic busy,
                       input logic ack, input logic rty, input logic [3:0] rtid);
    ireq_i     = mkReq(icyc, iadr);
    dreq_i     = mkReq(dcyc, dadr);
    bus_busy_i = busy;
    ftam_resp  = mkResp(ack, rty, rtid);
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.icyc, v.iadr, v.dcyc, v.dadr, v.busy, v.ack, v.rty, v.rtid);
    tick();
  endtask

  task automatic checkVector(input int n, input vec_t v);
    string t;
    t = $sformatf("v%0d", n);
    checkOutput({t, "_cyc"}, 32'(ftam_req.cyc), 32'(v.ecyc));
    if (v.ecyc) begin
      checkOutput({t, "_tid"}, 32'(ftam_req.tid.tranid), 32'(v.etid));
      checkOutput({t, "_adr"}, ftam_req.adr, v.eadr);
      checkOutput({t, "_core"}, 32'(ftam_req.tid.core), 32'd1);
      checkOutput({t, "_chan"}, 32'(ftam_req.tid.channel), 32'd1);
      checkOutput({t, "_cmd"}, 32'(ftam_req.cmd), 32'(CMD_LOAD));
    end else begin
      checkOutput({t, "_reqzero"}, 32'(ftam_req == '0), 32'd1);
    end
    checkOutput({t, "_irdy"}, 32'(irdy_o), 32'(v.eirdy));
    checkOutput({t, "_drdy"}, 32'(drdy_o), 32'(v.edrdy));
    checkOutput({t, "_iack"}, 32'(iresp_o.ack), 32'(v.eiack));
    checkOutput({t, "_irty"}, 32'(iresp_o.rty), 32'(v.eirty));
    checkOutput({t, "_dack"}, 32'(dresp_o.ack), 32'(v.edack));
    checkOutput({t, "_drty"}, 32'(dresp_o.rty), 32'(v.edrty));
    checkOutput({t, "_orph"}, 32'(orphan_o), 32'(v.eorph));
    checkOutput({t, "_out"}, 32'(outstanding_o), 32'(v.eout));
  endtask

  task automatic doReset();
    idle();
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    seen_tid.delete();
    seen_adr.delete();
  endtask

  initial begin
    rst_i = 1'b0;
    idle();

    // columns: icyc iadr dcyc dadr busy ack rty rtid | cyc tid adr irdy drdy iack irty dack drty orph out
    vecs[0]  = mk(0, 0,          1, 32'h1000, 0, 0, 0, 0,  0, 0, 0,          1, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0,          0, 0,        0, 0, 0, 0,  1, 1, 32'h1000,   1, 1, 0, 0, 0, 0, 0, 1);
    vecs[2]  = mk(0, 0,          0, 0,        0, 0, 0, 0,  0, 0, 0,          1, 1, 0, 0, 0, 0, 0, 1);
    vecs[3]  = mk(0, 0,          0, 0,        0, 1, 0, 1,  0, 0, 0,          1, 1, 0, 0, 1, 0, 0, 0);
    vecs[4]  = mk(0, 0,          0, 0,        0, 0, 0, 0,  0, 0, 0,          1, 1, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 32'h2000,   1, 32'h3000, 0, 0, 0, 0,  0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0,          0, 0,        0, 0, 0, 0,  1, 2, 32'h2000,   1, 0, 0, 0, 0, 0, 0, 1);
    vecs[7]  = mk(0, 0,          0, 0,        0, 0, 0, 0,  1, 3, 32'h3000,   1, 1, 0, 0, 0, 0, 0, 2);
    vecs[8]  = mk(1, 32'h2010,   1, 32'h3010, 0, 0, 0, 0,  0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 2);
    vecs[9]  = mk(0, 0,          0, 0,        0, 0, 0, 0,  1, 4, 32'h3010,   0, 1, 0, 0, 0, 0, 0, 3);
    vecs[10] = mk(0, 0,          0, 0,        0, 0, 0, 0,  1, 5, 32'h2010,   1, 1, 0, 0, 0, 0, 0, 4);
    vecs[11] = mk(0, 0,          0, 0,        0, 1, 0, 2,  0, 0, 0,          1, 1, 1, 0, 0, 0, 0, 3);
    vecs[12] = mk(0, 0,          0, 0,        0, 0, 1, 3,  0, 0, 0,          1, 1, 0, 0, 0, 1, 0, 2);
    vecs[13] = mk(0, 0,          0, 0,        0, 1, 0, 4,  0, 0, 0,          1, 1, 0, 0, 1, 0, 0, 1);
    vecs[14] = mk(0, 0,          0, 0,        0, 1, 0, 5,  0, 0, 0,          1, 1, 1, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 0,          0, 0,        0, 1, 0, 9,  0, 0, 0,          1, 1, 0, 0, 0, 0, 1, 0);
    vecs[16] = mk(0, 0,          0, 0,        0, 0, 0, 0,  0, 0, 0,          1, 1, 0, 0, 0, 0, 0, 0);

    tick();
    tick();
    checkOutput("rst_req", 32'(ftam_req == '0), 32'd1);
    checkOutput("rst_iresp", 32'(iresp_o == '0), 32'd1);
    checkOutput("rst_dresp", 32'(dresp_o == '0), 32'd1);
    checkOutput("rst_irdy", 32'(irdy_o), 32'd1);
    checkOutput("rst_drdy", 32'(drdy_o), 32'd1);
    checkOutput("rst_orph", 32'(orphan_o), 32'd0);
    checkOutput("rst_out", 32'(outstanding_o), 32'd0);
    rst_i = 1'b1;
    tick();

    for (int n = 0; n < 17; n++) begin
      applyStimulus(vecs[n]);
      checkVector(n, vecs[n]);
    end

    // Sequence A: MAX_OUT limit holds the fifth request until an ack frees a slot.
    doReset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 32'd0, 1'b1, 32'h4000 + 32'(k), 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      idle();
      tick();
    end
    tick();
    checkOutput("maxout_drdy", 32'(drdy_o), 32'd0);
    checkOutput("maxout_out", 32'(outstanding_o), 32'd4);
    checkOutput("maxout_cyc", 32'(ftam_req.cyc), 32'd0);
    checkOutput("maxout_cnt", 32'(seen_tid.size()), 32'd4);
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 4'd2);
    tick();
    idle();
    checkOutput("maxout_ack_dack", 32'(dresp_o.ack), 32'd1);
    checkOutput("maxout_ack_out", 32'(outstanding_o), 32'd3);
    checkOutput("maxout_ack_cyc", 32'(ftam_req.cyc), 32'd0);
    tick();
    checkOutput("maxout_fifth_cyc", 32'(ftam_req.cyc), 32'd1);
    checkOutput("maxout_fifth_tid", 32'(ftam_req.tid.tranid), 32'd5);
    checkOutput("maxout_fifth_adr", ftam_req.adr, 32'h4004);
    checkOutput("maxout_fifth_drdy", 32'(drdy_o), 32'd1);
    tick();
    checkOutput("maxout_seen", 32'(seen_tid.size()), 32'd5);
    for (int k = 0; k < 5 && k < seen_tid.size(); k++)
      checkOutput($sformatf("maxout_order%0d", k), 32'(seen_tid[k]), 32'(k + 1));

    // Sequence B: bus busy with both slots full, then a retry and a stale retry.
    doReset();
    drive(1'b1, 32'hA000, 1'b1, 32'hD000, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0);
      tick();
      checkOutput($sformatf("busy_cyc%0d", k), 32'(ftam_req.cyc), 32'd0);
      checkOutput($sformatf("busy_rdy%0d", k), 32'({irdy_o, drdy_o}), 32'd0);
    end
    idle();
    tick();
    checkOutput("busy_first_tid", 32'(ftam_req.tid.tranid), 32'd1);
    checkOutput("busy_first_adr", ftam_req.adr, 32'hA000);
    tick();
    checkOutput("busy_second_tid", 32'(ftam_req.tid.tranid), 32'd2);
    checkOutput("busy_second_adr", ftam_req.adr, 32'hD000);
    drive(1'b0, 32'd0, 1'b1, 32'hD010, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    idle();
    tick();
    checkOutput("rty_issue_tid", 32'(ftam_req.tid.tranid), 32'd3);
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 4'd3);
    tick();
    idle();
    checkOutput("rty_drty", 32'(dresp_o.rty), 32'd1);
    checkOutput("rty_dtid", 32'(dresp_o.tid.tranid), 32'd3);
    checkOutput("rty_ddat", dresp_o.dat[31:0], 32'hBEEF0003);
    checkOutput("rty_iresp", 32'(iresp_o == '0), 32'd1);
    checkOutput("rty_out", 32'(outstanding_o), 32'd2);
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 4'd3);
    tick();
    idle();
    checkOutput("rty_stale_orph", 32'(orphan_o), 32'd1);
    checkOutput("rty_stale_dresp", 32'(dresp_o == '0), 32'd1);
    tick();
    checkOutput("rty_stale_orph_end", 32'(orphan_o), 32'd0);

    // Sequence C: tranid wraps 15->1 and stalls while tid 1 is still owned.
    doReset();
    for (int k = 1; k <= 15; k++) begin
      drive(1'b0, 32'd0, 1'b1, 32'h5000 + 32'(k), 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      idle();
      tick();
      if (k != 1) begin
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 4'(k));
        tick();
        idle();
      end
    end
    drive(1'b0, 32'd0, 1'b1, 32'h5100, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    idle();
    tick();
    tick();
    tick();
    checkOutput("wrap_stall_drdy", 32'(drdy_o), 32'd0);
    checkOutput("wrap_stall_out", 32'(outstanding_o), 32'd1);
    checkOutput("wrap_stall_cyc", 32'(ftam_req.cyc), 32'd0);
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 4'd1);
    tick();
    idle();
    checkOutput("wrap_ack_out", 32'(outstanding_o), 32'd0);
    tick();
    checkOutput("wrap_reissue_cyc", 32'(ftam_req.cyc), 32'd1);
    checkOutput("wrap_reissue_tid", 32'(ftam_req.tid.tranid), 32'd1);
    checkOutput("wrap_reissue_adr", ftam_req.adr, 32'h5100);
    tick();
    checkOutput("wrap_seen", 32'(seen_tid.size()), 32'd16);
    for (int k = 0; k < 16 && k < seen_tid.size(); k++)
      checkOutput($sformatf("wrap_order%0d", k), 32'(seen_tid[k]), (k < 15) ? 32'(k + 1) : 32'd1);

    // Sequence D: asynchronous reset mid-flight, then the old response is an orphan.
    doReset();
    drive(1'b0, 32'd0, 1'b1, 32'h6000, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    idle();
    tick();
    checkOutput("arst_pre_cyc", 32'(ftam_req.cyc), 32'd1);
    checkOutput("arst_pre_out", 32'(outstanding_o), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    checkOutput("arst_req", 32'(ftam_req == '0), 32'd1);
    checkOutput("arst_out", 32'(outstanding_o), 32'd0);
    checkOutput("arst_drdy", 32'(drdy_o), 32'd1);
    tick();
    rst_i = 1'b1;
    tick();
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 4'd1);
    tick();
    idle();
    checkOutput("arst_orph", 32'(orphan_o), 32'd1);
    checkOutput("arst_dresp", 32'(dresp_o == '0), 32'd1);
    checkOutput("arst_iresp", 32'(iresp_o == '0), 32'd1);
    tick();
    checkOutput("arst_orph_end", 32'(orphan_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf80386_bus_arb.md
Name: rf80386_bus_arb

Overview:
- Two-requester arbiter and transaction tracker in front of the single fta 128-bit master port of the rf80386 core.
- Requester 0 is the instruction-cache line-fill engine; requester 1 is the core data path (loads, stores, I/O, descriptor and TSS reads).
- Each requester presents one-cycle request pulses. The arbiter buffers them, issues them round-robin, stamps the transaction ID and routes ack/rty responses back to the owning requester.

Parameters:
- CORENO, 6'd1, core number placed in tid.core of every issued request.
- CID, 3'd1, channel placed in tid.channel of every issued request.
- MAX_OUT, 4, maximum outstanding transactions on the bus (1..15).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-low reset.
- ireq_i  in  fta_cmd_request128_t  instruction requester command; valid when cyc=1.
- irdy_o  out  1  instruction holding slot empty; a request may be presented.
- iresp_o  out  fta_cmd_response128_t  response routed to requester 0.
- dreq_i  in  fta_cmd_request128_t  data requester command; valid when cyc=1.
- drdy_o  out  1  data holding slot empty.
- dresp_o  out  fta_cmd_response128_t  response routed to requester 1.
- ftam_req  out  fta_cmd_request128_t  arbitrated bus request.
- ftam_resp  in  fta_cmd_response128_t  bus response.
- bus_busy_i  in  1  downstream cannot accept a request this cycle.
- orphan_o  out  1  one-cycle pulse: response ack/rty carried an untracked tranid.
- outstanding_o  out  4  current count of outstanding transactions.

Behaviour:
Reset (rst_i=0, any time, asynchronous):
- Holding slots empty; owner table invalid; tranid counter = 1; round-robin pointer = 0 (instruction side first).
- All outputs zero: ftam_req all zero, iresp_o and dresp_o zero, orphan_o=0, outstanding_o=0, irdy_o=drdy_o=1.
- In-flight transactions are forgotten. Their later responses are orphans.

Capture:
- A request with cyc=1 while its rdy=1 is latched into that requester's slot on the same edge.
- A request with cyc=1 while rdy=0 is a protocol violation; it is ignored and not latched.
- rdy drops the cycle after capture and rises the cycle after the slot issues.

Issue (evaluated every cycle; at most one issue per cycle):
- Eligible when the slot is full, bus_busy_i=0, outstanding < MAX_OUT, and the owner-table entry at the current tranid is invalid.
- If both slots are eligible, the round-robin pointer selects; after an issue the pointer points to the other requester. If only one is eligible, it issues and the pointer is unchanged.
- ftam_req is registered: the slot contents are driven the cycle after eligibility, for exactly one cycle, with tid.core=CORENO, tid.channel=CID, tid.tranid=counter. All other cycles drive zero, with cmd=CMD_NONE.
- On issue: owner[tranid] <= {valid=1, requester}; counter increments and wraps 15->1 (0 is never used); outstanding increments.
- Minimum latency from capture to bus: 1 cycle, i.e. captured at edge N, ftam_req valid after edge N+1.

Response:
- When ftam_resp.ack or .rty is set, look up owner[ftam_resp.tid.tranid].
- If valid, forward the full response struct to that requester's resp output, registered with 1-cycle latency. The other resp output is zero. Invalidate the entry and decrement outstanding.
- If invalid, pulse orphan_o; no forwarding.
- A retry does not re-issue. The requester re-presents the request; its tid is new.
- Same-cycle issue and response: outstanding is adjusted by (+1 −1) = 0. The freed entry is usable for issue in the next cycle only.

Stalls:
- When the counter's entry is still valid, issue stalls. The counter does not skip ahead, so tranids stay strictly in order.

Decomposition:
- rf80386_pkg: owner_entry_t {valid, req}; constant NUM_TID = 16.
- fta_bus_pkg: supplies the request and response types and CMD_NONE.
- Sub-module rf80386_tid_table: 16-entry owner table with allocate port, lookup/free port, and outstanding counter. The arbiter FSM and slots stay in the top module.

Test Plan:
- Single data read: dreq cyc, adr=0x1000 -> ftam_req valid 1 cycle later with tranid=1, channel=CID; ack with tid 1 -> dresp_o.ack=1 one cycle later, iresp_o zero, outstanding returns 0.
- Simultaneous ireq and dreq from reset -> instruction issues first (tranid 1), data next cycle (tranid 2); repeated pairs alternate.
- MAX_OUT=4, five data requests with no acks -> tranids 1..4 issue, fifth held with drdy_o=0; ack tid 2 -> fifth issues with tranid 5 next cycle.
- 15 issued and unacked except tid 1 acked, MAX_OUT=15 -> counter wraps 15->1 and tid 1 reissues; tid 0 never appears.
- bus_busy_i=1 for 3 cycles with both slots full -> no issue; order is preserved afterwards. rty response with tid 3 -> routed to owner with rty=1, entry freed.
- Ack with untracked tid 9 -> orphan_o pulses once, no resp output. rst_i low mid-flight -> all outputs zero immediately; post-reset response for old tid -> orphan_o.
